// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: master encodings and
// the burst counter width helper.
package dmem_arbiter_pkg;

    localparam logic M_CPU = 1'b0;
    localparam logic M_IO  = 1'b1;

    // Enough bits to hold the values 0..max_burst inclusive.
    function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// and one I/O master, with a bounded I/O burst lock.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          io_req,
    input  logic          io_we,
    input  logic          io_lock,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic          io_ack,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = burst_cnt_width(MAX_BURST);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    logic          last_win_q, last_win_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          gnt_cpu, gnt_io;

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_io  = 1'b0;
        if (cpu_req && io_req) begin
            if (locked_q) begin
                // A locked burst may starve the CPU for at most MAX_BURST grants.
                if (burst_cnt_q < MAX_CNT) gnt_io = 1'b1;
                else                       gnt_cpu = 1'b1;
            end else if (last_win_q == M_IO) begin
                gnt_cpu = 1'b1;
            end else begin
                gnt_io = 1'b1;
            end
        end else begin
            gnt_cpu = cpu_req;
            gnt_io  = io_req;
        end
    end

    always_comb begin
        cpu_stall = cpu_req & ~gnt_cpu;
        io_ack    = gnt_io;
        mem_we    = (gnt_cpu & cpu_we) | (gnt_io & io_we);
        mem_addr  = gnt_io ? io_addr : cpu_addr;
        mem_wdata = gnt_io ? io_wdata : cpu_wdata;
        cpu_rdata = mem_rdata;
        io_rdata  = mem_rdata;
    end

    always_comb begin
        last_win_d  = last_win_q;
        locked_d    = gnt_io & io_lock;
        burst_cnt_d = burst_cnt_q;
        if (gnt_cpu)     last_win_d = M_CPU;
        else if (gnt_io) last_win_d = M_IO;
        if (gnt_io && locked_q && cpu_req) begin
            if (burst_cnt_q < MAX_CNT) burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (gnt_cpu || !locked_q) begin
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_win_q  <= M_IO;
            locked_q    <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            last_win_q  <= last_win_d;
            locked_q    <= locked_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomised checks of the data-memory arbiter against a
// behavioural memory and a small grant model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req, cpu_we, io_req, io_we, io_lock;
    logic [AW-1:0] cpu_addr, io_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, io_wdata, cpu_rdata, io_rdata, mem_wdata, mem_rdata;
    logic          cpu_stall, io_ack, mem_we;

    logic [DW-1:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (reset_n && mem_we) mem[mem_addr] <= mem_wdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .io_req(io_req), .io_we(io_we), .io_lock(io_lock), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic set_cpu(input logic req, input logic we, input logic [7:0] a,
                           input logic [7:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_io(input logic req, input logic we, input logic lock,
                          input logic [7:0] a, input logic [7:0] d);
        io_req = req; io_we = we; io_lock = lock; io_addr = a; io_wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(0, 0, 0, 8'h00, 8'h00);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(0, 0, 0, 8'h00, 8'h00);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || io_ack !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got stall=%b ack=%b we=%b want 0 0 0",
                     cpu_stall, io_ack, mem_we);
        end
        do_reset();
    endtask

    task automatic test_cpu_store_load();
        do_reset();
        set_cpu(1, 1, 8'h10, 8'hA5);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_store got we=%b stall=%b want 1 0", mem_we, cpu_stall);
        end
        checks++;
        if (mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_store_bus got addr=%h data=%h want 10 a5", mem_addr, mem_wdata);
        end
        next_cycle();
        set_cpu(1, 0, 8'h10, 8'h00);
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 8'hA5 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL cpu_load got rdata=%h stall=%b we=%b want a5 0 0",
                     cpu_rdata, cpu_stall, mem_we);
        end
        next_cycle();
        set_cpu(0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_idle();
        set_cpu(0, 1, 8'h44, 8'h11);
        set_io(0, 1, 0, 8'h55, 8'h22);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 8'h44 || mem_wdata !== 8'h11 ||
            io_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL idle got we=%b addr=%h data=%h ack=%b stall=%b want 0 44 11 0 0",
                     mem_we, mem_addr, mem_wdata, io_ack, cpu_stall);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_io;
        exp_io = 6'b101010;
        do_reset();
        set_cpu(1, 0, 8'h10, 8'h00);
        set_io(1, 0, 0, 8'h20, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (io_ack !== exp_io[i] || cpu_stall !== exp_io[i]) begin
                errors++;
                $display("FAIL rr_cycle%0d got ack=%b stall=%b want %b %b",
                         i, io_ack, cpu_stall, exp_io[i], exp_io[i]);
            end
            checks++;
            if (mem_addr !== (exp_io[i] ? 8'h20 : 8'h10)) begin
                errors++;
                $display("FAIL rr_addr%0d got %h want %h", i, mem_addr,
                         exp_io[i] ? 8'h20 : 8'h10);
            end
            next_cycle();
        end
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_burst_lock();
        logic [7:0] exp_io;
        // cycle 0: IO alone takes the lock; 1..4 locked grants; 5 CPU forced; 6 IO by rr; 7 CPU
        exp_io = 8'b0101_1111;
        do_reset();
        set_io(1, 0, 1, 8'h20, 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (i >= 1) set_cpu(1, 0, 8'h10, 8'h00);
            if (i >= 6) io_lock = 1'b0;
            @(negedge clk);
            checks++;
            if (io_ack !== exp_io[i] || cpu_stall !== (cpu_req & exp_io[i])) begin
                errors++;
                $display("FAIL burst_cycle%0d got ack=%b stall=%b want %b %b",
                         i, io_ack, cpu_stall, exp_io[i], cpu_req & exp_io[i]);
            end
            next_cycle();
        end
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_io_access();
        do_reset();
        set_cpu(1, 1, 8'h20, 8'h3C);
        next_cycle();
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(1, 0, 0, 8'h20, 8'h00);
        @(negedge clk);
        checks++;
        if (io_ack !== 1'b1 || io_rdata !== 8'h3C || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL io_read got ack=%b rdata=%h stall=%b we=%b want 1 3c 0 0",
                     io_ack, io_rdata, cpu_stall, mem_we);
        end
        next_cycle();
        set_io(1, 1, 0, 8'h30, 8'h77);
        @(negedge clk);
        checks++;
        if (io_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 8'h77) begin
            errors++;
            $display("FAIL io_write got ack=%b we=%b addr=%h data=%h want 1 1 30 77",
                     io_ack, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        set_io(0, 0, 0, 8'h00, 8'h00);
        set_cpu(1, 0, 8'h30, 8'h00);
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 8'h77) begin
            errors++;
            $display("FAIL io_write_readback got %h want 77", cpu_rdata);
        end
        next_cycle();
        set_cpu(0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_io(1, 0, 1, 8'h20, 8'h00);
        next_cycle();
        set_cpu(1, 0, 8'h10, 8'h00);
        repeat (2) next_cycle();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || io_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_burst got stall=%b ack=%b want 0 0", cpu_stall, io_ack);
        end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || io_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_first got stall=%b ack=%b want 0 0", cpu_stall, io_ack);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (io_ack !== 1'b1 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_second got ack=%b stall=%b want 1 1", io_ack, cpu_stall);
        end
        next_cycle();
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        logic       m_last, m_locked, e_gc, e_gi, acked;
        logic [2:0] m_cnt;
        int         wait_cnt;
        do_reset();
        m_last = 1'b1; m_locked = 1'b0; m_cnt = 3'd0; acked = 1'b0; wait_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom));
            if (!(io_req && !acked))
                set_io(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            else
                io_lock = 1'($urandom_range(0, 1));
            if (cpu_req && io_req) begin
                if (m_locked) begin
                    e_gi = (m_cnt < 3'(MB));
                    e_gc = ~e_gi;
                end else begin
                    e_gc = m_last;
                    e_gi = ~m_last;
                end
            end else begin
                e_gc = cpu_req;
                e_gi = io_req;
            end
            @(negedge clk);
            checks++;
            if (io_ack !== e_gi || cpu_stall !== (cpu_req & ~e_gc)) begin
                errors++;
                $display("FAIL rand%0d_grant got ack=%b stall=%b want %b %b",
                         i, io_ack, cpu_stall, e_gi, cpu_req & ~e_gc);
            end
            checks++;
            if (io_ack && cpu_req && !cpu_stall) begin
                errors++;
                $display("FAIL rand%0d_excl got both granted want one", i);
            end
            checks++;
            if (mem_we !== ((e_gc & cpu_we) | (e_gi & io_we))) begin
                errors++;
                $display("FAIL rand%0d_we got %b want %b", i, mem_we,
                         (e_gc & cpu_we) | (e_gi & io_we));
            end
            acked = io_ack;
            wait_cnt = (io_req && !io_ack) ? wait_cnt + 1 : 0;
            checks++;
            if (wait_cnt > 2) begin
                errors++;
                $display("FAIL rand%0d_io_starved got wait=%0d want <=2", i, wait_cnt);
            end
            if (e_gc) m_last = 1'b0;
            else if (e_gi) m_last = 1'b1;
            if (e_gi && m_locked && cpu_req) begin
                if (m_cnt < 3'(MB)) m_cnt = m_cnt + 3'd1;
            end else if (e_gc || !m_locked) begin
                m_cnt = 3'd0;
            end
            m_locked = e_gi & io_lock;
            next_cycle();
        end
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        set_cpu(0, 0, 8'h00, 8'h00);
        set_io(0, 0, 0, 8'h00, 8'h00);
        test_reset();
        test_cpu_store_load();
        test_idle();
        test_round_robin();
        test_burst_lock();
        test_io_access();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
